// File: rtl/dbus_uncached_bridge.sv
// Uncached data-bus bridge: turns one CPU dbus request into one single-beat
// cbus transaction and hands the result back.
// Ports: clk, reset (async, active-high), dreq/dresp (CPU side),
//        creq/cresp (interconnect side), busy (not IDLE).
package dbus_uncached_pkg;
  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1 = 8'd0;

  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module dbus_uncached_bridge
  import dbus_uncached_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [63:0] TIMEOUT_DATA   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [63:0] addr_q;
  logic [63:0] data_q;
  logic [63:0] result_q;
  msize_t      size_q;
  logic [7:0]  strobe_q;
  logic [31:0] cnt_q;

  logic        is_write;
  logic        timeout;

  assign is_write = |strobe_q;

  // Fires in the BUSY cycle that would bring the count to TIMEOUT_CYCLES.
  always_comb begin
    timeout = 1'b0;
    if (TIMEOUT_CYCLES != 0)
      timeout = (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (dreq.valid) state_nxt = BUSY;
      BUSY: begin
        if (cresp.ready) begin
          if (cresp.last) state_nxt = DONE;
        end else if (timeout) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dreq.valid) begin
            addr_q   <= dreq.addr;
            data_q   <= dreq.data;
            size_q   <= dreq.size;
            strobe_q <= dreq.strobe;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          // Beats without last still overwrite; the last one wins.
          if (cresp.ready) begin
            result_q <= is_write ? '0 : cresp.data;
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (timeout)
              result_q <= is_write ? '0 : TIMEOUT_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    creq          = '0;
    creq.valid    = (state == BUSY);
    creq.is_write = is_write;
    creq.size     = size_q;
    creq.addr     = addr_q;
    creq.strobe   = strobe_q;
    creq.data     = data_q;
    creq.len      = MLEN1;
    creq.burst    = AXI_BURST_FIXED;

    dresp = '0;
    if (state == DONE) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = result_q;
    end

    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Bench for dbus_uncached_bridge: directed vector table, random
// transactions checked against a transaction-level model, watchdog/reset.
module tb_dbus_uncached_bridge;
  import dbus_uncached_pkg::*;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq0, dreq1;
  dbus_resp_t dresp0, dresp1;
  cbus_req_t  creq0, creq1;
  cbus_resp_t cresp0, cresp1;
  logic       busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  dbus_uncached_bridge dut0 (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq0),
    .dresp (dresp0),
    .creq  (creq0),
    .cresp (cresp0),
    .busy  (busy0)
  );

  dbus_uncached_bridge #(
    .TIMEOUT_CYCLES (4)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq1),
    .dresp (dresp1),
    .creq  (creq1),
    .cresp (cresp1),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: sim still running, required finish");
    $fatal(1, "hang");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strb;
    logic [63:0] wd;
    int          gap;
    int          extra;
    logic [63:0] rd;
    logic [63:0] exp;
    bit          hold;
  } vec_t;

  // One dut0 transaction. Called at a negedge with dut0 in IDLE; returns at
  // the negedge of the IDLE cycle after DONE. gap = BUSY cycles without
  // ready, extra = ready beats without last, then one ready+last beat.
  task automatic do_txn(input string tag, input logic [63:0] addr,
                        input msize_t size, input logic [7:0] strb,
                        input logic [63:0] wd, input int gap,
                        input int extra, input logic [63:0] rd,
                        input logic [63:0] exp, input bit hold);
    int lat;
    bit seen;
    dreq0.valid  = 1'b1;
    dreq0.addr   = addr;
    dreq0.size   = size;
    dreq0.strobe = strb;
    dreq0.data   = wd;
    @(posedge clk);
    @(negedge clk);
    dreq0.addr   = 64'h2000_0000;
    dreq0.size   = ~size;
    dreq0.strobe = ~strb;
    dreq0.data   = ~wd;
    dreq0.valid  = hold;
    check({tag, "_busy"}, 64'(busy0), 64'd1);
    check({tag, "_cvalid"}, 64'(creq0.valid), 64'd1);
    check({tag, "_iswr"}, 64'(creq0.is_write), 64'(strb != 8'd0));
    check({tag, "_caddr"}, creq0.addr, addr);
    check({tag, "_csize"}, 64'(creq0.size), 64'(size));
    check({tag, "_cstrb"}, 64'(creq0.strobe), 64'(strb));
    check({tag, "_cdata"}, creq0.data, wd);
    check({tag, "_lenburst"}, {54'd0, creq0.len, creq0.burst},
          {54'd0, MLEN1, AXI_BURST_FIXED});
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < gap + extra + 20 && !seen; c++) begin
      if (c < gap)
        cresp0 = '0;
      else if (c < gap + extra)
        cresp0 = '{ready: 1'b1, last: 1'b0, data: {$urandom, $urandom}};
      else if (c == gap + extra)
        cresp0 = '{ready: 1'b1, last: 1'b1, data: rd};
      else
        cresp0 = '0;
      @(posedge clk);
      lat++;
      @(negedge clk);
      cresp0 = '0;
      seen = dresp0.data_ok;
      if (!seen && creq0.addr !== addr)
        check({tag, "_stable"}, creq0.addr, addr);
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(gap + extra + 1));
    check({tag, "_addrok"}, 64'(dresp0.addr_ok), 64'd1);
    check({tag, "_rdata"}, dresp0.data, exp);
    check({tag, "_done_cv"}, 64'(creq0.valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(dresp0.data_ok), 64'd0);
    check({tag, "_idle"}, 64'(busy0), 64'd0);
  endtask

  // dut1 watchdog transaction: ready_at is the 0-based BUSY cycle carrying
  // ready+last, or -1 for none.
  task automatic to_txn(input string tag, input logic [7:0] strb,
                        input int ready_at, input logic [63:0] rd,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    bit seen;
    dreq1 = '{valid: 1'b1, addr: 64'h1F00_0000, size: MSIZE8,
              strobe: strb, data: 64'h1111_2222_3333_4444};
    @(posedge clk);
    @(negedge clk);
    dreq1.valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (c == ready_at)
        cresp1 = '{ready: 1'b1, last: 1'b1, data: rd};
      else
        cresp1 = '0;
      @(posedge clk);
      lat++;
      @(negedge clk);
      cresp1 = '0;
      seen = dresp1.data_ok;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, dresp1.data, exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, 64'(busy1), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int ok_cnt;
    vecs[0] = '{64'h1000_0008, MSIZE4, 8'h00, 64'h0, 1, 0,
                64'h0000_00AB_0000_0000, 64'h0000_00AB_0000_0000, 1'b0};
    vecs[1] = '{64'h1000_0008, MSIZE1, 8'b0000_0100,
                64'h0000_0000_00CD_0000, 0, 0,
                64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1'b0};
    vecs[2] = '{64'h1000_0100, MSIZE2, 8'h00, 64'h0, 0, 2,
                64'h0000_0000_0000_0055, 64'h0000_0000_0000_0055, 1'b1};
    vecs[3] = '{64'h8000_0000, MSIZE8, 8'h00, 64'h0, 5, 0,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[4] = '{64'h1000_0003, MSIZE8, 8'hFF, 64'hCAFE_F00D_0000_0001,
                2, 1, 64'h7777_7777_7777_7777, 64'h0, 1'b0};
    vecs[5] = '{64'h1000_0020, MSIZE4, 8'h00, 64'h0, 0, 0,
                64'hAAAA_0000_BBBB_0000, 64'hAAAA_0000_BBBB_0000, 1'b1};
    vecs[6] = '{64'h1000_0024, MSIZE4, 8'h00, 64'h0, 0, 0,
                64'h0000_CCCC_0000_DDDD, 64'h0000_CCCC_0000_DDDD, 1'b0};

    reset  = 1'b1;
    dreq0  = '0;
    dreq1  = '0;
    cresp0 = '0;
    cresp1 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_creq_zero", 64'(creq0 == '0), 64'd1);
    check("rst_dresp_zero", 64'(dresp0 == '0), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].size,
             vecs[i].strb, vecs[i].wd, vecs[i].gap, vecs[i].extra,
             vecs[i].rd, vecs[i].exp, vecs[i].hold);
    dreq0.valid = 1'b0;
    @(negedge clk);

    // Random transactions; the model result is 0 for writes, else the
    // final (last) beat's data, latency one cycle per BUSY beat.
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a, w, r;
      logic [7:0]  s;
      int          g, e;
      a = {$urandom, $urandom};
      w = {$urandom, $urandom};
      r = {$urandom, $urandom};
      s = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      g = $urandom_range(5);
      e = ($urandom_range(3) == 0) ? $urandom_range(2) : 0;
      do_txn($sformatf("rnd%0d", i), a, msize_t'($urandom_range(3)), s, w,
             g, e, r, (s != 8'h00) ? 64'h0 : r, 1'($urandom_range(1)));
    end
    dreq0.valid = 1'b0;
    @(negedge clk);

    to_txn("to_read", 8'h00, -1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4);
    to_txn("to_race", 8'h00, 3, 64'h0000_0000_1234_5678,
           64'h0000_0000_1234_5678, 4);
    to_txn("to_write", 8'h0F, -1, 64'h0, 64'h0, 4);
    to_txn("to_early", 8'h00, 1, 64'h0000_0000_0000_00EE,
           64'h0000_0000_0000_00EE, 2);

    // Watchdog disabled on dut0: it waits indefinitely.
    dreq0 = '{valid: 1'b1, addr: 64'h1000_0040, size: MSIZE4,
              strobe: 8'h00, data: 64'h0};
    @(posedge clk);
    @(negedge clk);
    dreq0.valid = 1'b0;
    ok_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (dresp0.data_ok) ok_cnt++;
    end
    check("nowd_okcnt", 64'(ok_cnt), 64'd0);
    check("nowd_busy", 64'(busy0), 64'd1);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("arst_cvalid", 64'(creq0.valid), 64'd0);
    check("arst_busy", 64'(busy0), 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    do_txn("post_rst", 64'h1000_0008, MSIZE4, 8'h00, 64'h0, 0, 0,
           64'h5A5A_5A5A_0000_0001, 64'h5A5A_5A5A_0000_0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_uncached_bridge.md
Name: dbus_uncached_bridge

Overview:
- Converts one CPU data-bus request (dbus_req_t) into one single-beat cache-bus transaction (cbus_req_t).
- Returns the result on dbus_resp_t.
- Sits between the memory stage / data-cache bypass path and the cbus interconnect; used for uncached (MMIO) accesses.
- Holds one outstanding transaction at a time and keeps its own copy of the request, so creq stays stable after acceptance.

Parameters:
TIMEOUT_CYCLES, 0, cycles spent in BUSY with no cresp.ready before forced completion; 0 disables the watchdog.
TIMEOUT_DATA, 64'hFFFF_FFFF_FFFF_FFFF, value returned on dresp.data when the watchdog fires.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
dreq  in  dbus_req_t (140)  CPU request; held stable by the CPU until data_ok
dresp  out  dbus_resp_t (66)  addr_ok/data_ok/data to the CPU
creq  out  cbus_req_t (151)  request to the interconnect
cresp  in  cbus_resp_t (66)  ready/last/data from the interconnect
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, BUSY, DONE. Reset value is IDLE.
- Reset values: all outputs 0, internal request register 0, timeout counter 0.

IDLE:
- If dreq.valid: latch addr, size, strobe and data into the request register; go to BUSY.
- creq.valid is 0 in IDLE.

BUSY:
- creq fields (all come from the request register, never from live dreq):
  - valid = 1
  - is_write = |strobe
  - size = latched size
  - addr = latched addr
  - strobe = latched strobe
  - data = latched data
  - len = MLEN1
  - burst = AXI_BURST_FIXED
- On cresp.ready: capture cresp.data into the result register.
  - If cresp.last is also high: go to DONE.
  - If cresp.ready arrives without last (protocol violation for MLEN1): still capture, stay in BUSY until a beat with last; each capture overwrites the previous one.
- For writes the captured data is don't-care; dresp.data for a write completion is 0.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter is cleared on entry to BUSY and increments every BUSY cycle without cresp.ready.
  - When the counter reaches TIMEOUT_CYCLES, the result is TIMEOUT_DATA (read) or 0 (write); go to DONE.
  - If cresp.ready arrives on that same cycle, cresp wins over the timeout.

DONE:
- Exactly one cycle with dresp.addr_ok = dresp.data_ok = 1 and dresp.data = result; creq.valid = 0. Then go to IDLE.

Latency and throughput:
- dresp.addr_ok and dresp.data_ok are asserted only in DONE, and always together.
- Minimum latency from dreq.valid to data_ok is 3 cycles (IDLE accept, BUSY with ready+last, DONE).
- A new request is accepted in the IDLE cycle that follows DONE; back-to-back maximum is one transaction per 3 cycles.

Other rules:
- Changes to dreq while BUSY or DONE are ignored.
- dreq.valid dropping mid-transaction does not abort it: the transaction completes and data_ok is still pulsed.
- No address-alignment check is performed; addr, size and strobe pass through unmodified.
- Reset asserted mid-transaction: state is IDLE and creq.valid = 0 immediately (asynchronous). The in-flight cbus transaction is abandoned; the interconnect shares the same reset.
- cresp inputs are ignored in IDLE and DONE.

Test Plan:
- Read: dreq = {valid=1, addr=64'h1000_0008, size=MSIZE4, strobe=0}. Interconnect returns ready+last with data 64'h0000_00AB_0000_0000 on the 2nd BUSY cycle -> creq shows is_write=0, len=MLEN1, burst=FIXED, addr=64'h1000_0008; data_ok for exactly one cycle with dresp.data = 64'h0000_00AB_0000_0000; busy falls the cycle after.
- Write: strobe=8'b0000_0100, data=64'h0000_0000_00CD_0000 -> creq.is_write=1 with the same strobe and data; data_ok pulse with dresp.data = 0.
- Stability: change dreq.addr to 64'h2000_0000 while BUSY -> creq.addr stays 64'h1000_0008 until completion.
- Timeout: TIMEOUT_CYCLES=4, no ready -> DONE after 4 BUSY cycles with dresp.data = 64'hFFFF_FFFF_FFFF_FFFF. Variant with ready arriving on the 4th BUSY cycle -> cresp data is returned, not the timeout value.
- Reset mid-BUSY: assert reset between clock edges -> creq.valid and busy go to 0 without waiting for a clock edge; the next request after release completes normally.
- Back-to-back: two reads with dreq.valid held high across both -> exactly two creq transactions, two data_ok pulses, IDLE separating them.
